// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I access-width encodings,
// FSM states and the funct3 legality rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_t;

  // Stores only have signed-width encodings; loads add the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/halfword extract with sign/zero
// extension, and store lane merge into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_lane,
  input  logic [2:0]  ld_funct3,
  output logic [31:0] ld_data,
  input  logic [31:0] st_word,
  input  logic [1:0]  st_lane,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_data,
  output logic [31:0] st_merged
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  always_comb begin
    ld_byte   = ld_word[{ld_lane, 3'b000} +: 8];
    ld_half   = ld_word[{ld_lane[1], 4'b0000} +: 16];
    ld_signed = ~ld_funct3[2];
    case (ld_funct3[1:0])
      2'b00:   ld_data = {{24{ld_byte[7] & ld_signed}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ld_signed}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  always_comb begin
    st_merged = st_word;
    case (st_funct3[1:0])
      2'b00:   st_merged[{st_lane, 3'b000} +: 8] = st_data[7:0];
      2'b01:   st_merged[{st_lane[1], 4'b0000} +: 16] = st_data[15:0];
      default: st_merged = st_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: single-word memory port, registered
// responses, and a read-modify-write for SB/SH since memory lacks byte enables.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        dbg_state
);

  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  lsu_state_t  state, state_next;
  logic [31:0] cap_word;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [2:0]  cap_f3;

  logic        accept;
  logic        misaligned;
  logic        fault;
  logic [31:0] ld_data;
  logic [31:0] st_merged;

  // Handshake: a request transfers on any rising edge where req_valid and
  // req_ready are both high; the requester holds it stable while ready is low.
  // Responses are one-cycle pulses with no backpressure.
  assign accept     = req_valid && req_ready;
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign fault      = !f3_legal(req_we, req_funct3) || misaligned ||
                      ({1'b0, req_addr} >= MEM_BYTES);
  assign dbg_state  = state;

  lsu_align u_align (
    .ld_word   (mem_rd),
    .ld_lane   (req_addr[1:0]),
    .ld_funct3 (req_funct3),
    .ld_data   (ld_data),
    .st_word   (cap_word),
    .st_lane   (cap_addr[1:0]),
    .st_funct3 (cap_f3),
    .st_data   (cap_wdata),
    .st_merged (st_merged)
  );

  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE);
    mem_we     = 1'b0;
    mem_a      = {req_addr[31:2], 2'b00};
    mem_wd     = req_wdata;
    case (state)
      IDLE: begin
        if (accept && !fault && req_we) begin
          if (req_funct3 == F3_W) mem_we = 1'b1;
          else                    state_next = MERGE;
        end
      end
      MERGE: begin
        // Write data comes only from captured registers, never from mem_rd.
        mem_we     = 1'b1;
        mem_a      = {cap_addr[31:2], 2'b00};
        mem_wd     = st_merged;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= 32'd0;
      cap_word   <= 32'd0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      cap_f3     <= 3'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= 32'd0;
      if (state == MERGE) begin
        resp_valid <= 1'b1;
      end else if (accept) begin
        if (fault) begin
          resp_valid <= 1'b1;
          resp_fault <= 1'b1;
        end else if (!req_we) begin
          resp_valid <= 1'b1;
          resp_rdata <= ld_data;
        end else if (req_funct3 == F3_W) begin
          resp_valid <= 1'b1;
        end else begin
          cap_word  <= mem_rd;
          cap_addr  <= req_addr;
          cap_wdata <= req_wdata;
          cap_f3    <= req_funct3;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios then random requests checked
// against a byte-addressed reference memory and an expected-response queue.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_WORDS = 1024;

  typedef struct {
    int          due;
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        dbg_state;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd),
    .dbg_state  (dbg_state)
  );

  // data memory attached to the DUT, with a bench-side preload port
  logic [31:0] mem [0:MEM_WORDS-1];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_idx = 10'd0;
  logic [31:0] tb_data = 32'd0;
  assign mem_rd = mem[mem_a[11:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[11:2]] <= mem_wd;
    if (tb_we)  mem[tb_idx] <= tb_data;
  end

  // scoreboard
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  exp_t        exp_q[$];
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step_resp();
    logic exp_v;
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("resp_valid", 32'(resp_valid), 32'(exp_v));
    if (exp_v) begin
      check("resp_fault", 32'(resp_fault), 32'(exp_q[0].fault));
      check("resp_rdata", resp_rdata, exp_q[0].rdata);
      exp_q.delete(0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step_resp();
      @(posedge clk);
      #1;
    end
  endtask

  // driver: presents one request in IDLE, checks the memory port and, for
  // SB/SH, the MERGE cycle; queues the expected response from the model.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    longint      a;
    int          sz, sh, lat;
    logic        legal, flt;
    logic [31:0] oldw, neww, v, mask;
    exp_t        e;
    a     = longint'(addr);
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    flt   = !legal || (a % sz != 0) || (a >= longint'(MEM_WORDS * 4));
    sh    = int'(a % 4) * 8;
    oldw  = flt ? 32'd0 : ref_mem[a / 4];
    neww  = oldw;
    v     = 32'd0;
    mask  = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (!flt && !we) begin
      v = (oldw >> sh) & mask;
      if (!f3[2] && sz == 1 && v >= 32'd128)   v = v - 32'd256;
      if (!f3[2] && sz == 2 && v >= 32'd32768) v = v - 32'd65536;
    end
    if (!flt && we) begin
      neww = (oldw & ~(mask << sh)) | ((wd & mask) << sh);
      ref_mem[a / 4] = neww;
    end
    lat = (!flt && we && sz < 4) ? 2 : 1;

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    step_resp();
    check("req_ready", 32'(req_ready), 32'd1);
    check("accept_mem_we", 32'(mem_we), 32'(!flt && we && sz == 4));
    if (!flt) check("accept_mem_a", mem_a, {addr[31:2], 2'b00});
    if (!flt && we && sz == 4) check("sw_mem_wd", mem_wd, wd);
    e.due   = cyc + lat;
    e.fault = flt;
    e.rdata = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (lat == 2) begin
      @(negedge clk);
      step_resp();
      check("merge_ready", 32'(req_ready), 32'd0);
      check("merge_we", 32'(mem_we), 32'd1);
      check("merge_a", mem_a, {addr[31:2], 2'b00});
      check("merge_wd", mem_wd, neww);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          sz;

    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom();
    ref_mem[2] = 32'h8899_AABB;

    // preload memory while reset is held
    @(posedge clk);
    #1;
    for (int i = 0; i < MEM_WORDS; i++) begin
      tb_we   = 1'b1;
      tb_idx  = 10'(i);
      tb_data = ref_mem[i];
      @(posedge clk);
      #1;
    end
    tb_we = 1'b0;

    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // sub-word loads from word 2
    issue(1'b0, F3_B,  32'h9, 32'd0);
    issue(1'b0, F3_BU, 32'h9, 32'd0);
    issue(1'b0, F3_H,  32'hA, 32'd0);
    issue(1'b0, F3_HU, 32'hA, 32'd0);

    // SW then LW back-to-back, then SB into the same word
    issue(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, F3_W, 32'h10, 32'd0);
    issue(1'b1, F3_B, 32'h12, 32'h0000_0055);
    idle(1);
    check("sb_word", mem[4], 32'hDE55_BEEF);
    issue(1'b0, F3_W, 32'h10, 32'd0);
    issue(1'b1, F3_H, 32'h12, 32'h1234_ABCD);

    // faults
    issue(1'b0, F3_W, 32'h2, 32'd0);
    issue(1'b1, F3_H, 32'h3, 32'hFFFF_FFFF);
    issue(1'b0, 3'b011, 32'h4, 32'd0);
    issue(1'b0, F3_W, 32'h1000, 32'd0);
    issue(1'b1, F3_W, 32'hFFFF_FFFC, 32'h1111_1111);
    idle(2);

    // reset asserted during MERGE drops the pending write
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'h25;
    req_wdata  = 32'h0000_00C3;
    @(negedge clk);
    step_resp();
    check("rstm_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rstm_merge_we", 32'(mem_we), 32'd1);
    check("rstm_state", 32'(dbg_state), 32'(MERGE));
    #2;
    rst = 1'b1;
    #1;
    check("rstm_we_drop", 32'(mem_we), 32'd0);
    check("rstm_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("rstm_no_resp2", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstm_ready_after", 32'(req_ready), 32'd1);
    check("rstm_state_after", 32'(dbg_state), 32'(IDLE));
    step_resp();
    check("rstm_mem_unchanged", mem[9], ref_mem[9]);
    @(posedge clk);
    #1;
    issue(1'b0, F3_W, 32'h24, 32'd0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = F3_B;
            1: f3 = F3_H;
            2: f3 = F3_W;
            3: f3 = F3_BU;
            default: f3 = F3_HU;
          endcase
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      addr = 32'($urandom_range(0, MEM_WORDS * 4 - 1));
      if ($urandom_range(0, 4) != 0) addr = addr - (addr % 32'(sz));
      if ($urandom_range(0, 19) == 0) addr = 32'(MEM_WORDS * 4) + 32'($urandom_range(0, 65535));
      issue(we, f3, addr, $urandom());
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage initiator for the pipelined RISC-V core. It accepts one load/store request per handshake from the pipeline and drives the word-wide data memory port (`mem_we`, `mem_a`, `mem_wd`, `mem_rd`). It performs byte/halfword extraction with sign or zero extension, and uses a two-cycle read-modify-write for SB/SH because the memory has no byte enables. It flags misaligned, illegal and out-of-range accesses without touching memory.

## Interface
- `MEM_WORDS`, 1024: memory depth in 32-bit words. Byte addresses at or above `MEM_WORDS*4` fault.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; transfer occurs when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 of the access.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low bits are used for SB/SH.
- `resp_valid` out 1: one-cycle response pulse, for loads and stores alike.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `resp_fault` out 1: access rejected; qualified by `resp_valid`.
- `mem_we` out 1: memory write enable.
- `mem_a` out 32: word-aligned byte address `{addr[31:2],2'b00}`.
- `mem_wd` out 32: memory write data.
- `mem_rd` in 32: combinational memory read data.

## Operation
- States: IDLE, MERGE. Reset enters IDLE.
- IDLE: `req_ready`=1.
  - On acceptance, decode the request.
  - Loads are LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores are SB 000, SH 001, SW 010.
- Fault conditions, checked before any memory action:
  - any other funct3;
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - `addr` ≥ `MEM_WORDS*4`.
  - On fault: `mem_we`=0, next cycle `resp_valid`=1, `resp_fault`=1, `resp_rdata`=0. Remain in IDLE.
- Load: drive `mem_a`. Register the lane selected by `addr[1:0]`, sign- or zero-extended, into `resp_rdata`. Pulse `resp_valid` next cycle. Remain in IDLE.
- SW: `mem_we`=1 and `mem_wd`=`req_wdata` in the accept cycle. Next cycle `resp_valid`=1, `resp_rdata`=0.
- SB/SH:
  - In the accept cycle, read only; `mem_we`=0.
  - Capture `mem_rd`, the address and the store data. Go to MERGE.
- MERGE: `req_ready`=0. Drive `mem_we`=1 at the held address with the captured word, replacing the addressed byte or halfword lane with the low store bits. Return to IDLE; `resp_valid` pulses the next cycle.
- `mem_rd` must never feed `mem_wd` combinationally in the same cycle.
- When no access is in progress, `mem_we`=0 and `mem_a`/`mem_wd` are don't-care.

## Timing
- Reset values:
  - state = IDLE;
  - `resp_valid`, `resp_fault`, `mem_we` = 0;
  - `resp_rdata` = 0;
  - internal capture registers = 0;
  - `req_ready`=1 once reset deasserts.
- Latency from acceptance to `resp_valid`:
  - loads, SW and faults: 1 cycle;
  - SB/SH: 2 cycles.
- Throughput:
  - one load/SW/fault per cycle, back-to-back;
  - a new request may be accepted in the same cycle a response is presented.
  - SB/SH blocks acceptance for exactly one cycle (MERGE).
- `resp_valid` is a single-cycle pulse per accepted request. There is no backpressure on the response.
- Reset during MERGE: the pending write is dropped (`mem_we` forced 0 asynchronously) and no response is issued.
- `req_valid` while `req_ready`=0: ignored. The requester holds the request.

## Structure
- Package `lsu_pkg`: funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`), state enum (IDLE, MERGE).
- Sub-module `lsu_align` (combinational): load lane extract/extend from (word, `addr[1:0]`, funct3), and store lane merge. The top level keeps only the FSM, handshake and registers.

## Test plan
- Preload word 2 with 0x8899AABB. LB at 0x9 → `resp_rdata` 0xFFFFFFAA. LBU at 0x9 → 0x000000AA. LH at 0xA → 0xFFFF8899. Each response arrives 1 cycle after acceptance.
- SW 0xDEADBEEF to 0x10, then LW 0x10 back-to-back → `mem_we`=1 in the accept cycle, then `resp_rdata` 0xDEADBEEF. `req_ready` stays 1 throughout.
- Word at 0x10 = 0xDEADBEEF; SB 0x55 to 0x12 → `req_ready`=0 for one cycle, memory holds 0xDE55BEEF, `resp_valid` 2 cycles after acceptance.
- LW at 0x2, SH at 0x3, funct3 011, and LW at 0x1000 with `MEM_WORDS`=1024 → each gives `resp_fault`=1, `mem_we` never asserted.
- Assert `rst` while in MERGE → `mem_we` drops immediately, memory unchanged, no `resp_valid`, IDLE with `req_ready`=1 after release.
